// File: rtl/prach_pkg.sv
// Shared types and defaults for the PRACH half-band pre-stage (phase splitter + ping-pong buffer).
package prach_pkg;

  localparam int unsigned NUM_CHANNEL_DEF = 16;
  localparam int unsigned DATA_WIDTH_DEF  = 16;

  typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/prach_pp_ram.sv
// Ping-pong frame store: 2 banks x 2 phases x N words, one write port and a
// paired phase-0/phase-1 read with one cycle of latency.
module prach_pp_ram
  import prach_pkg::*;
#(
  parameter int unsigned NUM_CHANNEL = NUM_CHANNEL_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  localparam int unsigned CW         = $clog2(NUM_CHANNEL)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  wbank_i,
  input  logic                  wphase_i,
  input  logic [CW-1:0]         wchn_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rbank_i,
  input  logic [CW-1:0]         rchn_i,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o
);

  logic [DATA_WIDTH-1:0] mem_q [4*NUM_CHANNEL];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{wbank_i, wphase_i, wchn_i}] <= wdata_i;
    end
    rdata0_o <= mem_q[{rbank_i, 1'b0, rchn_i}];
    rdata1_o <= mem_q[{rbank_i, 1'b1, rchn_i}];
  end

endmodule

// File: rtl/prach_hb1_pre.sv
// Phase splitter feeding prach_hb1_ch: buffers a two-phase TDM pair frame and
// re-emits it as one dense N-cycle burst of (even, odd) sample pairs.
module prach_hb1_pre
  import prach_pkg::*;
#(
  parameter int unsigned NUM_CHANNEL = NUM_CHANNEL_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] din_dq,
  input  logic                         din_dv,
  input  logic [7:0]                   din_chn,
  input  logic                         sync_in,
  output logic signed [DATA_WIDTH-1:0] dout_dp1,
  output logic signed [DATA_WIDTH-1:0] dout_dp2,
  output logic                         dout_dv,
  output logic [7:0]                   dout_chn,
  output logic                         sync_out,
  output logic                         err_seq
);

  localparam int unsigned CW = $clog2(NUM_CHANNEL);
  localparam int unsigned IW = CW + 1;
  localparam logic [IW-1:0] LastIdx = IW'(2 * NUM_CHANNEL - 1);
  localparam logic [CW-1:0] LastChn = CW'(NUM_CHANNEL - 1);

  logic [IW-1:0] wr_idx_q, wr_idx_d, idx_eff;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    sync_tag_q, sync_tag_d, tag_eff;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic          start_bank_q, start_bank_d;
  logic          start_sync_q, start_sync_d;
  logic          we;

  rd_state_e     state_q, state_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic          rd_sync_q, rd_sync_d;
  logic          rbank;
  logic [CW-1:0] rchn;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  // Writer: sync_in rewinds the index before the same-cycle write is placed.
  always_comb begin
    idx_eff = sync_in ? '0 : wr_idx_q;
    tag_eff = sync_tag_q;
    if (sync_in) tag_eff[wr_bank_q] = 1'b1;
    wr_idx_d     = idx_eff;
    wr_bank_d    = wr_bank_q;
    sync_tag_d   = tag_eff;
    err_d        = err_q;
    start_d      = 1'b0;
    start_bank_d = start_bank_q;
    start_sync_d = start_sync_q;
    we           = 1'b0;
    if (din_dv) begin
      if (din_chn == 8'(idx_eff[CW-1:0])) begin
        we = 1'b1;
        if (idx_eff == LastIdx) begin
          wr_idx_d               = '0;
          wr_bank_d              = ~wr_bank_q;
          start_d                = 1'b1;
          start_bank_d           = wr_bank_q;
          start_sync_d           = tag_eff[wr_bank_q];
          sync_tag_d[wr_bank_q]  = 1'b0;
        end else begin
          wr_idx_d = idx_eff + 1'b1;
        end
      end else begin
        err_d    = 1'b1;
        wr_idx_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q     <= '0;
      wr_bank_q    <= 1'b0;
      sync_tag_q   <= '0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      start_bank_q <= 1'b0;
      start_sync_q <= 1'b0;
    end else begin
      wr_idx_q     <= wr_idx_d;
      wr_bank_q    <= wr_bank_d;
      sync_tag_q   <= sync_tag_d;
      err_q        <= err_d;
      start_q      <= start_d;
      start_bank_q <= start_bank_d;
      start_sync_q <= start_sync_d;
    end
  end

  prach_pp_ram #(
    .NUM_CHANNEL (NUM_CHANNEL),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_ram (
    .clk_i    (clk),
    .we_i     (we),
    .wbank_i  (wr_bank_q),
    .wphase_i (idx_eff[CW]),
    .wchn_i   (idx_eff[CW-1:0]),
    .wdata_i  (din_dq),
    .rbank_i  (rbank),
    .rchn_i   (rchn),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_sync_q <= rd_sync_d;
    end
  end

  // A start arriving mid-drain cannot happen with legal input rates and is ignored.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_sync_d = rd_sync_q;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d   = DRAIN;
          rd_cnt_d  = '0;
          rd_bank_d = start_bank_q;
          rd_sync_d = start_sync_q;
        end
      end
      DRAIN: begin
        if (rd_cnt_q == LastChn) state_d = IDLE;
        else                     rd_cnt_d = rd_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read one word ahead so the RAM latency lines up with the drain counter.
  always_comb begin
    if (state_q == DRAIN) begin
      rbank = rd_bank_q;
      rchn  = rd_cnt_q + 1'b1;
    end else begin
      rbank = start_bank_q;
      rchn  = '0;
    end
  end

  always_comb begin
    dout_dv  = (state_q == DRAIN);
    dout_dp2 = dout_dv ? rdata0 : '0;
    dout_dp1 = dout_dv ? rdata1 : '0;
    dout_chn = dout_dv ? 8'(rd_cnt_q) : 8'd0;
    sync_out = dout_dv && (rd_cnt_q == '0) && rd_sync_q;
    err_seq  = err_q;
  end

endmodule

// File: tb/tb_prach_hb1_pre.sv
// Bench for prach_hb1_pre: frame table plus hand sequences, scoreboard of burst beats.
module tb_prach_hb1_pre;
  import prach_pkg::*;

  localparam int N = 16;

  logic    clk = 1'b0;
  logic    rst_n;
  sample_t din_dq;
  logic    din_dv;
  logic [7:0] din_chn;
  logic    sync_in;
  sample_t dout_dp1, dout_dp2;
  logic    dout_dv;
  logic [7:0] dout_chn;
  logic    sync_out, err_seq;

  prach_hb1_pre #(
    .NUM_CHANNEL (N),
    .DATA_WIDTH  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_dq   (din_dq),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dp1 (dout_dp1),
    .dout_dp2 (dout_dp2),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out),
    .err_seq  (err_seq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int dp2;
    int dp1;
    int chn;
    int sy;
    int cyc;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    int base;
    bit sparse;
    int pre;
    bit sync;
    bit exp_sync;
    bit exp_err;
  } vec_t;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit dv, input int chn, input int dq, input bit sy);
    @(negedge clk);
    din_dv  = dv;
    din_chn = 8'(chn);
    din_dq  = sample_t'(dq);
    sync_in = sy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
  endtask

  // Called right after the last sample of a pair frame is driven.
  task automatic push_burst(input int base, input bit sy);
    for (int c = 0; c < N; c++) begin
      exp_q.push_back('{dp2: base + c, dp1: base + N + c, chn: c,
                        sy: (sy && c == 0) ? 1 : 0, cyc: cyc + 2 + c});
    end
  endtask

  task automatic send_frame(input int base, input bit sparse, input bit sy, input bit exp_sy);
    for (int j = 0; j < 2 * N; j++) begin
      if (sparse && j > 0) idle(1);
      drive(1'b1, j % N, base + j, sy && j == 0);
    end
    push_burst(base, exp_sy);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dut.start_q && dut.state_q == DRAIN) begin
        errors++;
        $display("FAIL bank_conflict: rd_start while draining at cycle %0d", cyc);
      end
      if (dout_dv) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: chn %0d at cycle %0d, none expected", dout_chn, cyc);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_cycle", cyc, e.cyc);
          check("beat_chn", dout_chn, e.chn);
          check("beat_dp2", dout_dp2, e.dp2);
          check("beat_dp1", dout_dp1, e.dp1);
          check("beat_sync", sync_out, e.sy);
        end
      end else begin
        check("idle_sync_out", sync_out, 0);
      end
    end
  end

  vec_t vecs[8];

  initial begin
    bit found;
    vecs[0] = '{base: 100,  sparse: 0, pre: 0, sync: 0, exp_sync: 0, exp_err: 0};
    vecs[1] = '{base: 100,  sparse: 1, pre: 0, sync: 0, exp_sync: 0, exp_err: 0};
    vecs[2] = '{base: 1000, sparse: 0, pre: 0, sync: 0, exp_sync: 0, exp_err: 0};
    vecs[3] = '{base: 2000, sparse: 0, pre: 0, sync: 0, exp_sync: 0, exp_err: 0};
    vecs[4] = '{base: 3000, sparse: 0, pre: 0, sync: 0, exp_sync: 0, exp_err: 0};
    vecs[5] = '{base: 4000, sparse: 0, pre: 0, sync: 0, exp_sync: 0, exp_err: 0};
    vecs[6] = '{base: 600,  sparse: 0, pre: 5, sync: 1, exp_sync: 1, exp_err: 0};
    vecs[7] = '{base: 700,  sparse: 0, pre: 0, sync: 0, exp_sync: 0, exp_err: 0};

    rst_n = 1'b0; din_dv = 1'b0; din_chn = '0; din_dq = '0; sync_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dv", dout_dv, 0);
    check("reset_dp2", dout_dp2, 0);
    check("reset_dp1", dout_dp1, 0);
    check("reset_chn", dout_chn, 0);
    check("reset_sync", sync_out, 0);
    check("reset_err", err_seq, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int p = 0; p < vecs[i].pre; p++) drive(1'b1, p, 900 + p, 1'b0);
      send_frame(vecs[i].base, vecs[i].sparse, vecs[i].sync, vecs[i].exp_sync);
      check("frame_err_seq", err_seq, vecs[i].exp_err);
    end
    idle(N + 4);
    check("table_all_beats_seen", exp_q.size(), 0);

    // Sequence error: chn 7 where 6 is expected, then a clean frame.
    for (int c = 0; c < 6; c++) drive(1'b1, c, 50 + c, 1'b0);
    drive(1'b1, 7, 57, 1'b0);
    idle(1);
    check("seq_err_set", err_seq, 1);
    idle(3 * N);
    check("seq_err_no_burst", exp_q.size(), 0);
    send_frame(7000, 1'b0, 1'b0, 1'b0);
    idle(N + 4);
    check("seq_err_sticky", err_seq, 1);
    check("seq_err_recover", exp_q.size(), 0);

    // Reset on burst cycle 5.
    send_frame(5000, 1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 4 * N && !found; i++) begin
      idle(1);
      if (dout_dv && dout_chn == 8'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_burst_wait: burst cycle 5 not reached, got none expected 1");
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dv", dout_dv, 0);
    check("async_rst_dp2", dout_dp2, 0);
    check("async_rst_dp1", dout_dp1, 0);
    check("async_rst_chn", dout_chn, 0);
    check("async_rst_err", err_seq, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(3 * N);
    send_frame(6000, 1'b0, 1'b0, 1'b0);
    idle(N + 4);
    check("post_reset_beats_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prach_hb1_pre.md
Name: prach_hb1_pre

Overview:
- Phase splitter and ping-pong frame buffer directly upstream of the 16-channel TDM half-band decimator prach_hb1_ch.
- Accepts one TDM complex-component sample per cycle: channel order 0..N-1, phase 0 frame followed by phase 1 frame.
- Re-emits each channel's sample pair as one dense N-cycle burst, dp2 = phase 0 (even sample) and dp1 = phase 1 (odd sample), in the format the decimator's delay lines expect.

Parameters:
- NUM_CHANNEL, 16, TDM channels per frame; power of two, 2..128.
- DATA_WIDTH, 16, sample width in bits, signed two's complement.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- din_dq  input  DATA_WIDTH  input sample.
- din_dv  input  1  input sample valid.
- din_chn  input  8  input channel index.
- sync_in  input  1  frame sync, restarts pair-frame assembly.
- dout_dp1  output  DATA_WIDTH  odd-phase sample (phase 1).
- dout_dp2  output  DATA_WIDTH  even-phase sample (phase 0).
- dout_dv  output  1  output valid, high for exactly N consecutive cycles per burst.
- dout_chn  output  8  output channel index, 0..N-1 within a burst.
- sync_out  output  1  high on the first burst cycle of a sync-aligned pair frame.
- err_seq  output  1  sticky channel-sequence error.

Behaviour:
- Reset: asynchronous, active-low, clears all state.
  - Outputs reset to zero.
  - wr_idx=0, wr_bank=0, state IDLE, sync tags 0, err_seq 0.
  - Buffer RAM contents are don't-care.
- Storage: two banks × 2 phases × N words.
- Writer, wr_idx in 0..2N-1, with phase = wr_idx/N and expected channel = wr_idx mod N:
  - On din_dv with din_chn == expected: write din_dq to bank[wr_bank][phase][chn] and increment wr_idx.
  - At wr_idx = 2N-1: wrap to 0, toggle wr_bank, pulse rd_start carrying the completed bank number.
  - On din_dv with din_chn mismatch: drop the sample, set err_seq, set wr_idx to 0. The partial frame is discarded; wr_bank and its sync tag are unchanged.
- sync_in:
  - Forces wr_idx to 0 before any same-cycle write, so a same-cycle valid sample is written at index 0 (channel must be 0, else error).
  - Sets sync_tag[wr_bank]=1.
  - Any partial frame is discarded.
- Writer sync tag: cleared when the bank is handed to the reader.
- Reader FSM, IDLE / DRAIN:
  - IDLE: on rd_start, go to DRAIN with rd_bank = completed bank and rd_cnt = 0.
  - DRAIN, each cycle: register dout_dp2 = bank[rd_bank][0][rd_cnt], dout_dp1 = bank[rd_bank][1][rd_cnt], dout_chn = rd_cnt, dout_dv = 1.
  - DRAIN, first cycle only: sync_out = captured sync tag.
  - At rd_cnt = N-1: return to IDLE.
- Outside DRAIN: dout_dv=0, dout_dp1/dp2=0, dout_chn=0, sync_out=0.
- Latency: if the 2N-th sample's din_dv is at cycle T, dout_dv is high on cycles T+2..T+N+1.
- Bank conflict: refilling a bank takes at least 2N cycles and a drain takes N, so rd_start cannot arrive during DRAIN. This is a bench assertion; the RTL ignores such a rd_start.
- Idle input cycles (din_dv=0) pause the writer only; a burst in progress is never interrupted.
- din_chn values ≥ N always count as a mismatch.
- Output order within a burst is strictly 0..N-1, with no gaps.

Decomposition:
- Package prach_pkg holds:
  - NUM_CHANNEL default.
  - The sample typedef, logic signed [DATA_WIDTH-1:0].
  - The reader state enum {IDLE, DRAIN}.
- One sub-module, prach_pp_ram: simple dual-port RAM with 1-cycle read latency. Depth 4N (bank, phase, channel), one write port and two read ports (phase 0 and phase 1 read together), inferred as distributed RAM.

Test Plan:
- Basic pair frame: after reset, 32 dense samples, chn 0..15 twice, value = 100+index. Expect a 16-cycle burst starting at T+2 with dp2=100+c, dp1=116+c, chn=c.
- Sparse input: same frame with din_dv toggling every other cycle. Expect the identical burst, starting 2 cycles after the 32nd valid sample.
- Back-to-back frames: 4 continuous pair frames. Expect 4 bursts spaced 32 cycles apart, banks alternating, data matching each frame, err_seq=0.
- Sync alignment: 5 samples, then sync_in with a valid sample for chn 0 in the same cycle, then 31 more samples. Expect exactly one burst; sync_out high only on its chn-0 cycle; the first 5 samples never appear.
- Sequence error: chn 7 arrives where 6 is expected. Expect err_seq=1 and held sticky, no burst for that frame, and the next clean 32 samples producing a correct burst.
- Reset mid-burst: assert rst_n low on burst cycle 5. Expect all outputs 0 immediately (asynchronously), no resumed burst after release, and a fresh frame working normally.
